draw_bug: RTL and testbench

DRAW_BUG -- requirements
Module: draw_bug

---
 rtl/draw_bug_pkg.sv | 28 ++
 rtl/draw_bug_if.sv | 43 ++++
 rtl/draw_bug_bug_ctl.sv | 137 +++++++++++++
 rtl/draw_bug.sv | 90 +++++++++
 tb/tb_draw_bug.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_bug_pkg.sv
// Shared definitions for the bug sprite game block: screen geometry, sprite
// defaults, FSM encoding and the video timing bundle carried through the pipeline.
package draw_bug_pkg;

  localparam int SCREEN_WIDTH  = 1024;
  localparam int SCREEN_HEIGHT = 768;
  localparam int SPRITE_W_DEF  = 54;
  localparam int SPRITE_H_DEF  = 53;
  localparam int START_X       = 100;
  localparam int START_Y       = 100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_HIDDEN = 2'd2
  } bug_state_t;

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } timing_t;

endpackage

// File: rtl/draw_bug_if.sv
// Video/pointer/ROM bus of the bug sprite block. The slave side is the
// compositor; the master side drives timing, pointer and ROM data.
interface draw_bug_if;
  logic        enable;
  logic        mouse_left;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [11:0] hcount_in;
  logic [11:0] vcount_in;
  logic        hsync_in;
  logic        hblnk_in;
  logic        vsync_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] rgb_pixel;
  logic [11:0] pixel_addr;
  logic [11:0] hcount_out;
  logic [11:0] vcount_out;
  logic        hsync_out;
  logic        hblnk_out;
  logic        vsync_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;
  logic [7:0]  hit_count;

  modport slave (
    input  enable, mouse_left, xpos, ypos,
    input  hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb_in,
    input  rgb_pixel,
    output pixel_addr,
    output hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out,
    output rgb_out, hit_count
  );

  modport master (
    output enable, mouse_left, xpos, ypos,
    output hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb_in,
    output rgb_pixel,
    input  pixel_addr,
    input  hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out,
    input  rgb_out, hit_count
  );
endinterface

// File: rtl/draw_bug_bug_ctl.sv
// Bug position and game FSM: bounces the sprite once per frame, hides it for a
// fixed number of frames after a click lands on it, and counts hits.
module bug_ctl
  import draw_bug_pkg::*;
#(
  parameter int SPRITE_W    = SPRITE_W_DEF,
  parameter int SPRITE_H    = SPRITE_H_DEF,
  parameter int STEP        = 2,
  parameter int HIDE_FRAMES = 64
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic        mouse_left,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        vblnk,
  output logic [11:0] bug_x,
  output logic [11:0] bug_y,
  output logic        visible,
  output logic [7:0]  hit_count
);

  localparam logic [11:0] X_MAX   = 12'(SCREEN_WIDTH - SPRITE_W);
  localparam logic [11:0] Y_MAX   = 12'(SCREEN_HEIGHT - SPRITE_H);
  localparam logic [11:0] W_V     = 12'(SPRITE_W);
  localparam logic [11:0] H_V     = 12'(SPRITE_H);
  localparam logic [11:0] STEP_V  = 12'(STEP);
  localparam logic [11:0] START_XV = 12'(START_X);
  localparam logic [11:0] START_YV = 12'(START_Y);
  localparam int          CNT_W   = $clog2(HIDE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HIDE_FRAMES - 1);

  bug_state_t       state_r;
  logic [11:0]      bug_x_r, bug_y_r;
  logic             dir_x_r, dir_y_r;
  logic             visible_r;
  logic [7:0]       hit_cnt_r;
  logic [CNT_W-1:0] hide_cnt_r;
  logic             vblnk_prev_r;
  logic [12:0]      nx_s, ny_s;
  logic             frame_tick_s, hit_s;

  // One axis step: returns {new_dir, new_pos}; reaching an edge clamps and flips.
  function automatic logic [12:0] step_axis(input logic [11:0] pos, input logic dir_pos,
                                            input logic [11:0] lim, input logic [11:0] step);
    if (dir_pos) begin
      if (pos + step >= lim) return {1'b0, lim};
      else                   return {1'b1, pos + step};
    end else begin
      if (pos <= step)       return {1'b1, 12'd0};
      else                   return {1'b0, pos - step};
    end
  endfunction

  // Next-step candidates, frame edge detect and pointer hit test.
  always_comb begin
    nx_s         = step_axis(bug_x_r, dir_x_r, X_MAX, STEP_V);
    ny_s         = step_axis(bug_y_r, dir_y_r, Y_MAX, STEP_V);
    frame_tick_s = vblnk && !vblnk_prev_r;
    hit_s        = mouse_left && (xpos >= bug_x_r) && (xpos < bug_x_r + W_V)
                   && (ypos >= bug_y_r) && (ypos < bug_y_r + H_V);
  end

  // Game FSM with position, direction, hide timer and hit counter.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      bug_x_r      <= START_XV;
      bug_y_r      <= START_YV;
      dir_x_r      <= 1'b1;
      dir_y_r      <= 1'b1;
      visible_r    <= 1'b1;
      hit_cnt_r    <= 8'd0;
      hide_cnt_r   <= '0;
      vblnk_prev_r <= 1'b0;
    end else begin
      vblnk_prev_r <= vblnk;
      if (!enable) begin
        state_r    <= ST_IDLE;
        bug_x_r    <= START_XV;
        bug_y_r    <= START_YV;
        dir_x_r    <= 1'b1;
        dir_y_r    <= 1'b1;
        visible_r  <= 1'b1;
        hide_cnt_r <= '0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (frame_tick_s) begin
              state_r <= ST_MOVE;
              {dir_x_r, bug_x_r} <= nx_s;
              {dir_y_r, bug_y_r} <= ny_s;
            end
          end
          ST_MOVE: begin
            // A hit on the tick cycle freezes the position where it was clicked.
            if (hit_s) begin
              state_r    <= ST_HIDDEN;
              visible_r  <= 1'b0;
              hide_cnt_r <= '0;
              if (hit_cnt_r != 8'd255) hit_cnt_r <= hit_cnt_r + 8'd1;
            end else if (frame_tick_s) begin
              {dir_x_r, bug_x_r} <= nx_s;
              {dir_y_r, bug_y_r} <= ny_s;
            end
          end
          ST_HIDDEN: begin
            if (frame_tick_s) begin
              if (hide_cnt_r == CNT_LAST) begin
                state_r    <= ST_MOVE;
                visible_r  <= 1'b1;
                hide_cnt_r <= '0;
                bug_x_r    <= START_XV;
                bug_y_r    <= START_YV;
                dir_x_r    <= !dir_x_r;
                dir_y_r    <= !dir_y_r;
              end else begin
                hide_cnt_r <= hide_cnt_r + CNT_W'(1);
              end
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            visible_r <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bug_x     = bug_x_r;
  assign bug_y     = bug_y_r;
  assign visible   = visible_r;
  assign hit_count = hit_cnt_r;

endmodule

// File: rtl/draw_bug.sv
// Bug sprite compositor: two-stage pixel pipeline overlaying the ROM sprite on
// the incoming video, with position/game control in bug_ctl.
module draw_bug
  import draw_bug_pkg::*;
#(
  parameter int          SPRITE_W    = SPRITE_W_DEF,
  parameter int          SPRITE_H    = SPRITE_H_DEF,
  parameter int          STEP        = 2,
  parameter int          HIDE_FRAMES = 64,
  parameter logic [11:0] KEY_COLOR   = 12'hF0F
) (
  input logic       pclk,
  input logic       rst,
  draw_bug_if.slave bus
);

  localparam logic [11:0] W_V = 12'(SPRITE_W);
  localparam logic [11:0] H_V = 12'(SPRITE_H);

  timing_t     tim_in_s, tim_d1_r, tim_d2_r;
  logic [11:0] bug_x_s, bug_y_s;
  logic        visible_s;
  logic        inside_s, inside_d1_r, inside_d2_r;
  logic [11:0] addr_s, addr_r;
  logic [11:0] rgb_out_s;

  bug_ctl #(
    .SPRITE_W    (SPRITE_W),
    .SPRITE_H    (SPRITE_H),
    .STEP        (STEP),
    .HIDE_FRAMES (HIDE_FRAMES)
  ) u_ctl (
    .pclk       (pclk),
    .rst        (rst),
    .enable     (bus.enable),
    .mouse_left (bus.mouse_left),
    .xpos       (bus.xpos),
    .ypos       (bus.ypos),
    .vblnk      (bus.vblnk_in),
    .bug_x      (bug_x_s),
    .bug_y      (bug_y_s),
    .visible    (visible_s),
    .hit_count  (bus.hit_count)
  );

  // Stage-1 sprite window test and ROM address; position only moves on frame ticks.
  always_comb begin
    tim_in_s = '{hcount: bus.hcount_in, vcount: bus.vcount_in,
                 hsync: bus.hsync_in, hblnk: bus.hblnk_in,
                 vsync: bus.vsync_in, vblnk: bus.vblnk_in, rgb: bus.rgb_in};
    inside_s = !bus.hblnk_in && !bus.vblnk_in && visible_s
               && (bus.hcount_in >= bug_x_s) && (bus.hcount_in < bug_x_s + W_V)
               && (bus.vcount_in >= bug_y_s) && (bus.vcount_in < bug_y_s + H_V);
    if (inside_s) addr_s = 12'((bus.vcount_in - bug_y_s) * W_V + (bus.hcount_in - bug_x_s));
    else          addr_s = 12'd0;
  end

  // Two pipeline stages for timing, background and the inside flag.
  always_ff @(posedge pclk) begin
    if (rst) begin
      tim_d1_r    <= '0;
      tim_d2_r    <= '0;
      inside_d1_r <= 1'b0;
      inside_d2_r <= 1'b0;
      addr_r      <= 12'd0;
    end else begin
      tim_d1_r    <= tim_in_s;
      tim_d2_r    <= tim_d1_r;
      inside_d1_r <= inside_s;
      inside_d2_r <= inside_d1_r;
      addr_r      <= addr_s;
    end
  end

  // ROM word arrives registered by the ROM itself, aligned with stage 2.
  always_comb begin
    if (inside_d2_r && (bus.rgb_pixel != KEY_COLOR)) rgb_out_s = bus.rgb_pixel;
    else                                             rgb_out_s = tim_d2_r.rgb;
  end

  assign bus.pixel_addr = addr_r;
  assign bus.hcount_out = tim_d2_r.hcount;
  assign bus.vcount_out = tim_d2_r.vcount;
  assign bus.hsync_out  = tim_d2_r.hsync;
  assign bus.hblnk_out  = tim_d2_r.hblnk;
  assign bus.vsync_out  = tim_d2_r.vsync;
  assign bus.vblnk_out  = tim_d2_r.vblnk;
  assign bus.rgb_out    = rgb_out_s;

endmodule

// File: tb/tb_draw_bug.sv
// Directed bench for draw_bug with a synchronous sprite ROM model.
module tb_draw_bug;
  import draw_bug_pkg::*;

  logic pclk;
  logic rst;
  logic key_mode;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  draw_bug_if bus ();

  draw_bug u_dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic logic [11:0] rom_word(input logic [11:0] a);
    return {a[10:0], 1'b0} ^ 12'h2C4;
  endfunction

  always @(posedge pclk) bus.rgb_pixel <= key_mode ? 12'hF0F : rom_word(bus.pixel_addr);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_px(input logic [11:0] h, input logic [11:0] v, input logic hb,
                          input logic [11:0] rgb);
    bus.hcount_in = h;
    bus.vcount_in = v;
    bus.hblnk_in  = hb;
    bus.vblnk_in  = 1'b0;
    bus.rgb_in    = rgb;
  endtask

  task automatic frame();
    bus.vblnk_in = 1'b0;
    @(posedge pclk); #1;
    bus.vblnk_in = 1'b1;
    @(posedge pclk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_mode = 1'b0;
    bus.enable = 1'b0; bus.mouse_left = 1'b0; bus.xpos = 12'd0; bus.ypos = 12'd0;
    bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
    drive_px(12'd0, 12'd0, 1'b0, 12'd0);
    repeat (2) @(posedge pclk);
    #1 rst = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk_cnt++;
    if ({bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.hblnk_out, bus.vsync_out, bus.vblnk_out} !== 28'd0)
      $display("FAIL reset_timing: got %0h want 0", {bus.hcount_out, bus.vcount_out});
    else pass_cnt++;
    chk_cnt++;
    if ({bus.rgb_out, bus.pixel_addr} !== 24'd0)
      $display("FAIL reset_rgb_addr: got %0h want 0", {bus.rgb_out, bus.pixel_addr});
    else pass_cnt++;
    chk_cnt++;
    if (bus.hit_count !== 8'd0) $display("FAIL reset_hits: got %0d want 0", bus.hit_count);
    else pass_cnt++;
    chk_cnt++;
    if ({u_dut.u_ctl.bug_x_r, u_dut.u_ctl.bug_y_r} !== {12'd100, 12'd100})
      $display("FAIL reset_pos: got (%0d,%0d) want (100,100)", u_dut.u_ctl.bug_x_r, u_dut.u_ctl.bug_y_r);
    else pass_cnt++;
  endtask

  task automatic test_move_draw();
    logic [11:0] ph [6] = '{12'd120, 12'd121, 12'd119, 12'd173, 12'd174, 12'd120};
    logic [11:0] pv [6] = '{12'd120, 12'd120, 12'd120, 12'd172, 12'd120, 12'd173};
    logic [11:0] pr [6] = '{12'h123, 12'h456, 12'h789, 12'h0AB, 12'h0CD, 12'h0EF};
    logic [11:0] ea [6] = '{12'h000, 12'h001, 12'h000, 12'hB2D, 12'h000, 12'h000};
    logic [11:0] eo [6] = '{12'h2C4, 12'h2C6, 12'h789, 12'h49E, 12'h0CD, 12'h0EF};
    bus.enable = 1'b1;
    repeat (10) frame();
    chk_cnt++;
    if ({u_dut.u_ctl.bug_x_r, u_dut.u_ctl.bug_y_r} !== {12'd120, 12'd120})
      $display("FAIL move_pos: got (%0d,%0d) want (120,120)", u_dut.u_ctl.bug_x_r, u_dut.u_ctl.bug_y_r);
    else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive_px(ph[i], pv[i], 1'b0, pr[i]);
      @(posedge pclk); #1;
      if (i < 6) begin
        chk_cnt++;
        if (bus.pixel_addr !== ea[i]) $display("FAIL draw_addr[%0d]: got %0h want %0h", i, bus.pixel_addr, ea[i]);
        else pass_cnt++;
      end
      if (i > 0) begin
        chk_cnt++;
        if (bus.rgb_out !== eo[i-1]) $display("FAIL draw_rgb[%0d]: got %0h want %0h", i-1, bus.rgb_out, eo[i-1]);
        else pass_cnt++;
        chk_cnt++;
        if ({bus.hcount_out, bus.vcount_out} !== {ph[i-1], pv[i-1]})
          $display("FAIL draw_timing[%0d]: got (%0d,%0d) want (%0d,%0d)", i-1, bus.hcount_out, bus.vcount_out, ph[i-1], pv[i-1]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_hit_hide();
    bus.xpos = 12'd130; bus.ypos = 12'd130; bus.mouse_left = 1'b1;
    repeat (5) frame();
    bus.mouse_left = 1'b0;
    chk_cnt++;
    if (bus.hit_count !== 8'd1) $display("FAIL hit_once: got %0d want 1", bus.hit_count);
    else pass_cnt++;
    chk_cnt++;
    if (u_dut.u_ctl.state_r !== ST_HIDDEN) $display("FAIL hit_state: got %0d want %0d", u_dut.u_ctl.state_r, ST_HIDDEN);
    else pass_cnt++;
    drive_px(12'd130, 12'd130, 1'b0, 12'h3A1);
    @(posedge pclk); #1;
    chk_cnt++;
    if (bus.pixel_addr !== 12'd0) $display("FAIL hidden_addr: got %0h want 0", bus.pixel_addr);
    else pass_cnt++;
    @(posedge pclk); #1;
    chk_cnt++;
    if (bus.rgb_out !== 12'h3A1) $display("FAIL hidden_rgb: got %0h want 3a1", bus.rgb_out);
    else pass_cnt++;
    repeat (58) frame();
    chk_cnt++;
    if (u_dut.u_ctl.state_r !== ST_HIDDEN) $display("FAIL hidden_63: got %0d want %0d", u_dut.u_ctl.state_r, ST_HIDDEN);
    else pass_cnt++;
    frame();
    chk_cnt++;
    if ({u_dut.u_ctl.state_r, u_dut.u_ctl.bug_x_r, u_dut.u_ctl.bug_y_r, u_dut.u_ctl.dir_x_r, u_dut.u_ctl.dir_y_r}
        !== {ST_MOVE, 12'd100, 12'd100, 1'b0, 1'b0})
      $display("FAIL reappear: got st %0d (%0d,%0d) dir %b%b want st 1 (100,100) dir 00", u_dut.u_ctl.state_r,
               u_dut.u_ctl.bug_x_r, u_dut.u_ctl.bug_y_r, u_dut.u_ctl.dir_x_r, u_dut.u_ctl.dir_y_r);
    else pass_cnt++;
    drive_px(12'd100, 12'd100, 1'b0, 12'h111);
    repeat (2) @(posedge pclk);
    #1;
    chk_cnt++;
    if (bus.rgb_out !== 12'h2C4) $display("FAIL reappear_rgb: got %0h want 2c4", bus.rgb_out);
    else pass_cnt++;
    frame();
    chk_cnt++;
    if ({u_dut.u_ctl.bug_x_r, u_dut.u_ctl.bug_y_r} !== {12'd98, 12'd98})
      $display("FAIL inverted_step: got (%0d,%0d) want (98,98)", u_dut.u_ctl.bug_x_r, u_dut.u_ctl.bug_y_r);
    else pass_cnt++;
  endtask

  task automatic test_key_blank();
    key_mode = 1'b1;
    drive_px(12'd110, 12'd105, 1'b0, 12'h5B7);
    repeat (2) @(posedge pclk);
    #1;
    chk_cnt++;
    if (bus.rgb_out !== 12'h5B7) $display("FAIL key_color: got %0h want 5b7", bus.rgb_out);
    else pass_cnt++;
    key_mode = 1'b0;
    drive_px(12'd110, 12'd105, 1'b1, 12'h6C8);
    @(posedge pclk); #1;
    chk_cnt++;
    if (bus.pixel_addr !== 12'd0) $display("FAIL blank_addr: got %0h want 0", bus.pixel_addr);
    else pass_cnt++;
    @(posedge pclk); #1;
    chk_cnt++;
    if ({bus.rgb_out, bus.hblnk_out} !== {12'h6C8, 1'b1})
      $display("FAIL blank_rgb: got %0h/%b want 6c8/1", bus.rgb_out, bus.hblnk_out);
    else pass_cnt++;
    drive_px(12'd110, 12'd105, 1'b0, 12'h7D9);
    @(posedge pclk); #1;
    chk_cnt++;
    if (bus.pixel_addr !== 12'h186) $display("FAIL open_addr: got %0h want 186", bus.pixel_addr);
    else pass_cnt++;
    @(posedge pclk); #1;
    chk_cnt++;
    if (bus.rgb_out !== 12'h1C8) $display("FAIL open_rgb: got %0h want 1c8", bus.rgb_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_hidden();
    bus.enable = 1'b0;
    @(posedge pclk); #1;
    chk_cnt++;
    if ({u_dut.u_ctl.state_r, u_dut.u_ctl.bug_x_r, bus.hit_count} !== {ST_IDLE, 12'd100, 8'd1})
      $display("FAIL disable: got st %0d x %0d hits %0d want st 0 x 100 hits 1",
               u_dut.u_ctl.state_r, u_dut.u_ctl.bug_x_r, bus.hit_count);
    else pass_cnt++;
    bus.enable = 1'b1;
    frame();
    bus.xpos = 12'd110; bus.ypos = 12'd110; bus.mouse_left = 1'b1;
    @(posedge pclk); #1;
    bus.mouse_left = 1'b0;
    chk_cnt++;
    if (bus.hit_count !== 8'd2) $display("FAIL second_hit: got %0d want 2", bus.hit_count);
    else pass_cnt++;
    repeat (3) frame();
    chk_cnt++;
    if (int'(u_dut.u_ctl.hide_cnt_r) !== 3) $display("FAIL hide_cnt: got %0d want 3", u_dut.u_ctl.hide_cnt_r);
    else pass_cnt++;
    drive_px(12'd55, 12'd66, 1'b1, 12'hABC);
    bus.hsync_in = 1'b1;
    rst = 1'b1;
    @(posedge pclk); #1;
    rst = 1'b0;
    bus.hsync_in = 1'b0;
    chk_cnt++;
    if ({u_dut.u_ctl.state_r, bus.hit_count, bus.rgb_out, bus.pixel_addr, bus.hcount_out, bus.hsync_out, bus.hblnk_out}
        !== {ST_IDLE, 8'd0, 12'd0, 12'd0, 12'd0, 1'b0, 1'b0})
      $display("FAIL rst_hidden: got st %0d hits %0d rgb %0h addr %0h h %0d want all 0",
               u_dut.u_ctl.state_r, bus.hit_count, bus.rgb_out, bus.pixel_addr, bus.hcount_out);
    else pass_cnt++;
    chk_cnt++;
    if (int'(u_dut.u_ctl.hide_cnt_r) !== 0) $display("FAIL rst_hide_cnt: got %0d want 0", u_dut.u_ctl.hide_cnt_r);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    drive_px(12'd0, 12'd0, 1'b0, 12'd0);
    repeat (434) frame();
    chk_cnt++;
    if ({u_dut.u_ctl.bug_x_r, u_dut.u_ctl.dir_x_r, u_dut.u_ctl.bug_y_r} !== {12'd968, 1'b1, 12'd463})
      $display("FAIL bounce_pre: got x %0d dir %b y %0d want x 968 dir 1 y 463",
               u_dut.u_ctl.bug_x_r, u_dut.u_ctl.dir_x_r, u_dut.u_ctl.bug_y_r);
    else pass_cnt++;
    frame();
    chk_cnt++;
    if ({u_dut.u_ctl.bug_x_r, u_dut.u_ctl.dir_x_r, u_dut.u_ctl.bug_y_r} !== {12'd970, 1'b0, 12'd461})
      $display("FAIL bounce_edge: got x %0d dir %b y %0d want x 970 dir 0 y 461",
               u_dut.u_ctl.bug_x_r, u_dut.u_ctl.dir_x_r, u_dut.u_ctl.bug_y_r);
    else pass_cnt++;
    frame();
    chk_cnt++;
    if ({u_dut.u_ctl.bug_x_r, u_dut.u_ctl.bug_y_r} !== {12'd968, 12'd459})
      $display("FAIL bounce_back: got x %0d y %0d want x 968 y 459", u_dut.u_ctl.bug_x_r, u_dut.u_ctl.bug_y_r);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_move_draw();
    test_hit_hide();
    test_key_blank();
    test_reset_hidden();
    test_bounce();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
